// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-master to one-slave memory arbiter. A winning master's
//                command is latched onto the slave port and held stable
//                until the slave completes or the transaction times out.
//                After completion the arbiter waits for the winning master
//                to drop its request before it arbitrates again. Ties go to
//                the master that was not granted last.
//  Ports       : i_clk, i_reset            - clock, sync active-high reset
//                mN_exec/we/sel/addr/wdata - master N request (N = 0,1)
//                mN_busy/fin/rdata         - master N status and response
//                s_exec/we/sel/addr/wdata  - slave request
//                s_busy/fin/rdata          - slave status and response
//                o_grant                   - current or last owner of slave
//                o_err                     - one-cycle timeout abort pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        m0_exec,
    input  logic        m0_we,
    input  logic [2:0]  m0_sel,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_busy,
    output logic        m0_fin,
    output logic [31:0] m0_rdata,

    input  logic        m1_exec,
    input  logic        m1_we,
    input  logic [2:0]  m1_sel,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_busy,
    output logic        m1_fin,
    output logic [31:0] m1_rdata,

    output logic        s_exec,
    output logic        s_we,
    output logic [2:0]  s_sel,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_busy,
    input  logic        s_fin,
    input  logic [31:0] s_rdata,

    output logic        o_grant,
    output logic        o_err
);

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_count;
    logic               r_last_grant;

    logic               w_any_req;
    logic               w_winner;
    logic               w_owner_exec;
    logic               w_done;
    logic               w_timeout;
    logic [31:0]        w_done_data;

    assign w_any_req    = m0_exec | m1_exec;
    // Sole requester wins; on a tie the master not served last wins.
    assign w_winner     = (m0_exec & m1_exec) ? ~r_last_grant : m1_exec;
    assign w_owner_exec = o_grant ? m1_exec : m0_exec;

    // A slave completion on the timeout cycle wins over the abort.
    assign w_timeout    = (r_count == c_cnt_last) && !s_fin;
    assign w_done       = s_fin || (r_count == c_cnt_last);
    assign w_done_data  = s_fin ? s_rdata : 32'd0;

    assign m0_busy = (r_state != S_IDLE) || s_busy;
    assign m1_busy = (r_state != S_IDLE) || s_busy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_last_grant <= 1'b1;
            s_exec       <= 1'b0;
            s_we         <= 1'b0;
            s_sel        <= 3'b010;
            s_addr       <= 32'd0;
            s_wdata      <= 32'd0;
            m0_fin       <= 1'b0;
            m1_fin       <= 1'b0;
            m0_rdata     <= 32'd0;
            m1_rdata     <= 32'd0;
            o_err        <= 1'b0;
            o_grant      <= 1'b0;
        end else begin
            // Completion and error outputs are single-cycle pulses.
            m0_fin <= 1'b0;
            m1_fin <= 1'b0;
            o_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req && !s_busy) begin
                        o_grant <= w_winner;
                        if (w_winner) begin
                            s_we    <= m1_we;
                            s_sel   <= m1_sel;
                            s_addr  <= m1_addr;
                            s_wdata <= m1_wdata;
                        end else begin
                            s_we    <= m0_we;
                            s_sel   <= m0_sel;
                            s_addr  <= m0_addr;
                            s_wdata <= m0_wdata;
                        end
                        s_exec  <= 1'b1;
                        r_count <= '0;
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (w_done) begin
                        s_exec       <= 1'b0;
                        o_err        <= w_timeout;
                        r_last_grant <= o_grant;
                        r_state      <= S_RELEASE;
                        if (o_grant) begin
                            m1_fin   <= 1'b1;
                            m1_rdata <= w_done_data;
                        end else begin
                            m0_fin   <= 1'b1;
                            m0_rdata <= w_done_data;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                S_RELEASE: begin
                    // The other master's request is left pending here.
                    if (!w_owner_exec) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter. Expected
//                completions are queued when a request is driven and are
//                matched against each mN_fin pulse as it appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int TIMEOUT_CYCLES = 8;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        m0_exec, m0_we, m1_exec, m1_we;
    logic [2:0]  m0_sel, m1_sel;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_busy, m0_fin, m1_busy, m1_fin;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_exec, s_we, s_busy, s_fin;
    logic [2:0]  s_sel;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        o_grant, o_err;

    mem_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .m0_exec(m0_exec), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_busy(m0_busy), .m0_fin(m0_fin), .m0_rdata(m0_rdata),
        .m1_exec(m1_exec), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_busy(m1_busy), .m1_fin(m1_fin), .m1_rdata(m1_rdata),
        .s_exec(s_exec), .s_we(s_we), .s_sel(s_sel), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_busy(s_busy), .s_fin(s_fin), .s_rdata(s_rdata),
        .o_grant(o_grant), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          master;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cycles   = 0;
    int          last_fin_cycle = 0;

    // Slave model controls
    bit          slv_en;
    int          slv_lat;
    int          slv_cnt;
    bit          slv_done;
    bit          fin_force;
    logic [31:0] slv_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int m, input logic [31:0] d, input logic e);
        exp_t x;
        x.master = m;
        x.rdata  = d;
        x.err    = e;
        sb.push_back(x);
    endtask

    // One clock cycle: scoreboard check, master reaction, slave model.
    task automatic tick();
        exp_t e;
        @(negedge i_clk);
        cycles++;
        if (m0_fin || m1_fin) begin
            last_fin_cycle = cycles;
            chk("dual_fin", 32'(m0_fin & m1_fin), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_fin", {30'd0, m1_fin, m0_fin}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("fin_master", 32'(m1_fin), 32'(e.master));
                chk("fin_rdata", m1_fin ? m1_rdata : m0_rdata, e.rdata);
                chk("fin_err", 32'(o_err), 32'(e.err));
                chk("fin_grant", 32'(o_grant), 32'(e.master));
                grant_log.push_back(m1_fin ? 1 : 0);
            end
        end else begin
            chk("err_without_fin", 32'(o_err), 32'd0);
        end
        if (m0_fin) m0_exec = 1'b0;
        if (m1_fin) m1_exec = 1'b0;

        s_fin = 1'b0;
        if (fin_force) begin
            s_fin     = 1'b1;
            s_rdata   = 32'hBAD0_BAD0;
            fin_force = 1'b0;
        end else if (s_exec && !slv_done && slv_en) begin
            slv_cnt++;
            if (slv_cnt >= slv_lat) begin
                s_fin    = 1'b1;
                s_rdata  = slv_base ^ s_addr;
                slv_done = 1'b1;
            end
        end
        if (!s_exec) begin
            slv_cnt  = 0;
            slv_done = 1'b0;
        end
    endtask

    task automatic do_reset();
        m0_exec = 1'b0;
        m1_exec = 1'b0;
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        sb.delete();
        grant_log.delete();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int n;
        int exec_cnt;
        int iss0;
        int iss1;

        i_reset = 1'b1;
        m0_exec = 0; m0_we = 0; m0_sel = 3'b010; m0_addr = 0; m0_wdata = 0;
        m1_exec = 0; m1_we = 0; m1_sel = 3'b010; m1_addr = 0; m1_wdata = 0;
        s_busy = 0; s_fin = 0; s_rdata = 0;
        slv_en = 1; slv_lat = 3; slv_cnt = 0; slv_done = 0; fin_force = 0;
        slv_base = 32'h0;

        // Reset state
        do_reset();
        chk("rst_s_exec", 32'(s_exec), 32'd0);
        chk("rst_s_we", 32'(s_we), 32'd0);
        chk("rst_s_sel", 32'(s_sel), 32'd2);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_m0_busy", 32'(m0_busy), 32'd0);

        // m0 read at 0x10, slave answers after 3 cycles
        slv_lat = 3; slv_base = 32'hDEADBEFF;
        m0_we = 0; m0_sel = 3'b010; m0_addr = 32'h10;
        push_exp(0, 32'hDEADBEEF, 1'b0);
        start = cycles;
        m0_exec = 1'b1;
        tick();
        chk("rd_s_exec", 32'(s_exec), 32'd1);
        chk("rd_s_addr", s_addr, 32'h10);
        chk("rd_s_we", 32'(s_we), 32'd0);
        chk("rd_m0_busy", 32'(m0_busy), 32'd1);
        wait_drain(20);
        chk("rd_latency", 32'(last_fin_cycle - start), 32'd4);
        tick();
        chk("rd_fin_one_cycle", 32'(m0_fin), 32'd0);
        chk("rd_back_idle", 32'(m0_busy), 32'd0);
        chk("rd_m1_rdata", m1_rdata, 32'd0);

        // Simultaneous requests after reset: m0 then m1
        do_reset();
        slv_lat = 2; slv_base = 32'h0BAD_F00D;
        m0_addr = 32'h100; m1_addr = 32'h200;
        push_exp(0, slv_base ^ 32'h100, 1'b0);
        push_exp(1, slv_base ^ 32'h200, 1'b0);
        m0_exec = 1'b1; m1_exec = 1'b1;
        wait_drain(60);
        chk("tie_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            chk("tie_first", 32'(grant_log[0]), 32'd0);
            chk("tie_second", 32'(grant_log[1]), 32'd1);
        end
        tick(); tick();

        // m1 write; master inputs change while the slave is working
        slv_lat = 4;
        m1_we = 1; m1_sel = 3'b000; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        push_exp(1, slv_base ^ 32'h20, 1'b0);
        m1_exec = 1'b1;
        tick();
        chk("wr_s_exec", 32'(s_exec), 32'd1);
        m1_addr = 32'h99; m1_wdata = 32'hFFFF0000; m1_sel = 3'b111; m1_we = 0;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            chk("wr_s_addr", s_addr, 32'h20);
            chk("wr_s_wdata", s_wdata, 32'h12345678);
            chk("wr_s_sel", 32'(s_sel), 32'd0);
            chk("wr_s_we", 32'(s_we), 32'd1);
            tick();
            n++;
        end
        chk("wr_drain", 32'(sb.size()), 32'd0);
        m1_sel = 3'b010; m1_addr = 32'h200; m1_wdata = 0;
        tick(); tick();

        // Back-to-back: both masters keep requesting, grants alternate
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            push_exp(0, slv_base ^ 32'h100, 1'b0);
            push_exp(1, slv_base ^ 32'h200, 1'b0);
        end
        m0_exec = 1'b1; m1_exec = 1'b1;
        iss0 = 1; iss1 = 1;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
            if (!m0_exec && !m0_busy && iss0 < 3) begin m0_exec = 1'b1; iss0++; end
            if (!m1_exec && !m1_busy && iss1 < 3) begin m1_exec = 1'b1; iss1++; end
        end
        chk("b2b_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) chk("b2b_grant", 32'(grant_log[i]), 32'(i % 2));
        end
        tick(); tick();

        // Timeout: slave never finishes
        slv_en = 0;
        m0_addr = 32'h40;
        push_exp(0, 32'd0, 1'b1);
        m0_exec = 1'b1;
        exec_cnt = 0; n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
            if (s_exec) exec_cnt++;
        end
        chk("to_drain", 32'(sb.size()), 32'd0);
        chk("to_exec_cycles", 32'(exec_cnt), 32'd8);
        tick();
        chk("to_err_pulse", 32'(o_err), 32'd0);
        tick();
        slv_en = 1;

        // s_fin on the timeout cycle wins: normal completion, no error
        slv_lat = 8;
        m0_addr = 32'h44;
        push_exp(0, slv_base ^ 32'h44, 1'b0);
        start = cycles;
        m0_exec = 1'b1;
        wait_drain(40);
        chk("edge_latency", 32'(last_fin_cycle - start), 32'd9);
        tick(); tick();

        // Reset in the middle of a transaction, then a stray s_fin
        slv_en = 0;
        m0_addr = 32'h50;
        m0_exec = 1'b1;
        tick(); tick(); tick();
        chk("mid_s_exec", 32'(s_exec), 32'd1);
        i_reset = 1'b1;
        m0_exec = 1'b0;
        tick();
        i_reset = 1'b0;
        fin_force = 1'b1;
        tick(); tick(); tick();
        chk("mid_s_exec_rst", 32'(s_exec), 32'd0);
        chk("mid_s_sel_rst", 32'(s_sel), 32'd2);
        chk("mid_s_addr_rst", s_addr, 32'd0);
        chk("mid_s_wdata_rst", s_wdata, 32'd0);
        chk("mid_m0_fin", 32'(m0_fin), 32'd0);
        chk("mid_m0_rdata", m0_rdata, 32'd0);
        chk("mid_m1_rdata", m1_rdata, 32'd0);
        chk("mid_grant", 32'(o_grant), 32'd0);
        chk("mid_busy", 32'(m0_busy), 32'd0);
        slv_en = 1;

        // Slave busy holds off the issue
        slv_lat = 1;
        s_busy = 1'b1;
        m0_addr = 32'h60;
        push_exp(0, slv_base ^ 32'h60, 1'b0);
        m0_exec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sb_s_exec", 32'(s_exec), 32'd0);
            chk("sb_m0_busy", 32'(m0_busy), 32'd1);
        end
        s_busy = 1'b0;
        tick();
        chk("sb_issue", 32'(s_exec), 32'd1);
        chk("sb_addr", s_addr, 32'h60);
        wait_drain(20);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
